// File: rtl/counter_display_pkg.sv
// counter_display_pkg: shared definitions for the counter/display bank.
//   - parameter defaults for counter_display_bank
//   - active-low seven-segment constants, bit order {g,f,e,d,c,b,a}
//   - hex_to_seg(): 4-bit nibble -> segment pattern
package counter_display_pkg;

  localparam int NUM_CH_DEF      = 8;
  localparam int CNT_WIDTH_DEF   = 32;
  localparam int NUM_DIGITS_DEF  = 8;
  localparam int REFRESH_DIV_DEF = 100000;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/counter_display_bank_if.sv
// counter_display_bank_if: display bus between the counter bank and the
// digit scanner.
//   disp : value to be shown (CNT_WIDTH bits)
//   an   : digit enables, active low, one-hot-zero
//   seg  : segments {g,f,e,d,c,b,a}, active low
// master = side that owns the display value, slave = scanner.
interface counter_display_bank_if #(
  parameter int CNT_WIDTH  = 32,
  parameter int NUM_DIGITS = 8
);
  logic [CNT_WIDTH-1:0]  disp;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;

  modport master (output disp, input an, seg);
  modport slave  (input disp, output an, seg);
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes the display value over NUM_DIGITS
// seven-segment digits.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of counter_display_bank_if (disp in, an/seg out)
// Each digit slot lasts REFRESH_DIV clocks. AN and segment are registered
// together from the current digit index so they always switch on the same
// edge. Digits beyond CNT_WIDTH see zero-extended data and show 0.
module seven_seg_scanner
  import counter_display_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input logic                    clk,
  input logic                    rst,
  counter_display_bank_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W = $clog2(REFRESH_DIV);

  logic [REF_W-1:0]      ref_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  wrap;
  logic [31:0]           disp_ext;
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;

  assign wrap     = (ref_cnt == REF_W'(REFRESH_DIV - 1));
  assign disp_ext = 32'(bus.disp);
  assign nib      = disp_ext[{idx, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else begin
      ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
      if (wrap)
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= ~NUM_DIGITS'(1);
      seg_q <= SEG_ZERO;
    end else begin
      an_q  <= ~(NUM_DIGITS'(1) << idx);
      seg_q <= hex_to_seg(nib);
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule

// File: rtl/counter_display_bank.sv
// counter_display_bank: NUM_CH event counters with a selectable, freezable
// seven-segment hex readout.
//   CLK100MHZ : system clock (rising edge)
//   RESET     : asynchronous active-high reset
//   inc       : per-channel increment pulses (synchronous)
//   clr       : synchronous clear of counters and overflow flags
//   sel       : channel shown on the display
//   freeze    : hold display value and latched select while high
//   LED       : [7:0] one-hot latched select, [15:8] overflow flags
//   AN        : digit enables, active low
//   segment   : {g,f,e,d,c,b,a}, active low
// Optional feature: define COUNTER_OVERFLOW_EN for sticky per-channel
// overflow flags on LED[8+i]; otherwise LED[15:8] is tied to 0.
module counter_display_bank
  import counter_display_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic                  CLK100MHZ,
  input  logic                  RESET,
  input  logic [NUM_CH-1:0]     inc,
  input  logic                  clr,
  input  logic [3:0]            sel,
  input  logic                  freeze,
  output logic [15:0]           LED,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [6:0]            segment
);

  logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0]             sel_val;
  logic [CNT_WIDTH-1:0]             disp_q;
  logic [3:0]                       sel_q;
  logic [7:0]                       ch_led;
  logic [7:0]                       flag_led;

  // clr dominates a simultaneous increment
  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr)
          cnt[i] <= '0;
        else if (inc[i])
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

`ifdef COUNTER_OVERFLOW_EN
  logic [NUM_CH-1:0] ovf;

  // sticky; set when an all-ones counter is incremented
  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr)
          ovf[i] <= 1'b0;
        else if (inc[i] && (cnt[i] == '1))
          ovf[i] <= 1'b1;
      end
    end
  end

  assign flag_led = 8'(ovf);
`else
  assign flag_led = '0;
`endif

  // out-of-range select falls through to zero
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (sel == 4'(i)) sel_val = cnt[i];
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      disp_q <= '0;
      sel_q  <= '0;
    end else if (!freeze) begin
      disp_q <= sel_val;
      sel_q  <= sel;
    end
  end

  always_comb begin
    ch_led = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (sel_q == 4'(i)) ch_led[i] = 1'b1;
  end

  assign LED = {flag_led, ch_led};

  counter_display_bank_if #(
    .CNT_WIDTH (CNT_WIDTH),
    .NUM_DIGITS(NUM_DIGITS)
  ) disp_bus ();

  assign disp_bus.disp = disp_q;
  assign AN            = disp_bus.an;
  assign segment       = disp_bus.seg;

  seven_seg_scanner #(
    .CNT_WIDTH  (CNT_WIDTH),
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk(CLK100MHZ),
    .rst(RESET),
    .bus(disp_bus)
  );

endmodule

// File: tb/tb_counter_display_bank.sv
// tb_counter_display_bank: directed self-checking bench for
// counter_display_bank with NUM_CH=4, CNT_WIDTH=16, NUM_DIGITS=4,
// REFRESH_DIV=4. Inputs change 1ns after a rising edge; outputs are
// sampled at the same point, i.e. after the edge has settled.
module tb_counter_display_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  inc = '0;
  logic        clr = 1'b0;
  logic [3:0]  sel = '0;
  logic        freeze = 1'b0;
  logic [15:0] led;

  int n_chk  = 0;
  int n_pass = 0;

  counter_display_bank_if #(.CNT_WIDTH(16), .NUM_DIGITS(4)) mon ();

  counter_display_bank #(
    .NUM_CH(4), .CNT_WIDTH(16), .NUM_DIGITS(4), .REFRESH_DIV(4)
  ) dut (
    .CLK100MHZ(clk),
    .RESET    (rst),
    .inc      (inc),
    .clr      (clr),
    .sel      (sel),
    .freeze   (freeze),
    .LED      (led),
    .AN       (mon.an),
    .segment  (mon.seg)
  );

  assign mon.disp = dut.disp_q;

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] m, input int n);
    repeat (n) begin
      inc = m; tick();
      inc = '0; tick();
    end
  endtask

  task automatic test_reset;
    tick(3);
    n_chk++; if (mon.an !== 4'b1110) $display("FAIL rst_an: got %b want 1110", mon.an); else n_pass++;
    n_chk++; if (mon.seg !== 7'b1000000) $display("FAIL rst_seg: got %b want 1000000", mon.seg); else n_pass++;
    n_chk++; if (led !== 16'h0001) $display("FAIL rst_led: got %h want 0001", led); else n_pass++;
    rst = 1'b0; inc = 4'b0001;
    #1;
    n_chk++; if (mon.an !== 4'b1110) $display("FAIL rel_an: got %b want 1110", mon.an); else n_pass++;
    n_chk++; if (mon.seg !== 7'b1000000) $display("FAIL rel_seg: got %b want 1000000", mon.seg); else n_pass++;
    n_chk++; if (led !== 16'h0001) $display("FAIL rel_led: got %h want 0001", led); else n_pass++;
    tick();
    inc = '0;
    n_chk++; if (dut.cnt[0] !== 16'd1) $display("FAIL first_inc: got %0d want 1", dut.cnt[0]); else n_pass++;
  endtask

  task automatic test_scan;
    logic [3:0] an_seq [5];
    logic [3:0] prev;
    bit found;
    an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    clr = 1'b1; tick(); clr = 1'b0;
    sel = 4'd2;
    pulse(4'b0100, 5);
    tick(2);
    n_chk++; if (mon.disp !== 16'h0005) $display("FAIL scan_disp: got %h want 0005", mon.disp); else n_pass++;
    found = 0;
    prev = mon.an;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (prev !== 4'b1110 && mon.an === 4'b1110) found = 1;
      prev = mon.an;
    end
    n_chk++; if (!found) $display("FAIL scan_sync: got no AN entry to 1110 within 40 cycles"); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (mon.an !== an_seq[k]) $display("FAIL scan_an%0d: got %b want %b", k, mon.an, an_seq[k]); else n_pass++;
      n_chk++;
      if (mon.seg !== ((k % 4 == 0) ? 7'b0010010 : 7'b1000000))
        $display("FAIL scan_seg%0d: got %b want %b", k, mon.seg, (k % 4 == 0) ? 7'b0010010 : 7'b1000000);
      else n_pass++;
      tick(3);
      n_chk++; if (mon.an !== an_seq[k]) $display("FAIL scan_hold%0d: got %b want %b", k, mon.an, an_seq[k]); else n_pass++;
      tick();
    end
  endtask

  task automatic test_freeze;
    clr = 1'b1; tick(); clr = 1'b0;
    sel = 4'd0;
    pulse(4'b0001, 3);
    tick(2);
    n_chk++; if (mon.disp !== 16'h0003) $display("FAIL frz_pre: got %h want 0003", mon.disp); else n_pass++;
    freeze = 1'b1; sel = 4'd2;
    pulse(4'b0001, 4);
    tick(2);
    n_chk++; if (mon.disp !== 16'h0003) $display("FAIL frz_hold: got %h want 0003", mon.disp); else n_pass++;
    n_chk++; if (led[7:0] !== 8'h01) $display("FAIL frz_led: got %h want 01", led[7:0]); else n_pass++;
    n_chk++; if (dut.cnt[0] !== 16'd7) $display("FAIL frz_cnt: got %0d want 7", dut.cnt[0]); else n_pass++;
    sel = 4'd0; freeze = 1'b0;
    tick();
    n_chk++; if (mon.disp !== 16'h0007) $display("FAIL frz_rel: got %h want 0007", mon.disp); else n_pass++;
  endtask

  task automatic test_overflow;
    logic [7:0] exp_flags;
`ifdef COUNTER_OVERFLOW_EN
    exp_flags = 8'h02;
`else
    exp_flags = 8'h00;
`endif
    clr = 1'b1; tick(); clr = 1'b0;
    sel = 4'd1;
    inc = 4'b0010;
    tick(65535);
    inc = '0;
    tick();
    n_chk++; if (dut.cnt[1] !== 16'hFFFF) $display("FAIL ovf_pre: got %h want ffff", dut.cnt[1]); else n_pass++;
    n_chk++; if (led[15:8] !== 8'h00) $display("FAIL ovf_noflag: got %h want 00", led[15:8]); else n_pass++;
    n_chk++; if (led[7:0] !== 8'h02) $display("FAIL ovf_sel: got %h want 02", led[7:0]); else n_pass++;
    inc = 4'b0010; tick(); inc = '0;
    n_chk++; if (dut.cnt[1] !== 16'h0000) $display("FAIL ovf_wrap: got %h want 0000", dut.cnt[1]); else n_pass++;
    n_chk++; if (led[15:8] !== exp_flags) $display("FAIL ovf_flag: got %h want %h", led[15:8], exp_flags); else n_pass++;
    tick(3);
    n_chk++; if (led[15:8] !== exp_flags) $display("FAIL ovf_sticky: got %h want %h", led[15:8], exp_flags); else n_pass++;
  endtask

  task automatic test_clr_sel;
    pulse(4'b0001, 1);
    clr = 1'b1; inc = 4'b0001; tick();
    clr = 1'b0; inc = '0;
    n_chk++; if (dut.cnt[0] !== 16'd0) $display("FAIL clr_win: got %0d want 0", dut.cnt[0]); else n_pass++;
    n_chk++; if (led[15:8] !== 8'h00) $display("FAIL clr_flags: got %h want 00", led[15:8]); else n_pass++;
    pulse(4'b1111, 1);
    sel = 4'd5;
    tick(2);
    n_chk++; if (mon.disp !== 16'h0000) $display("FAIL sel_oor_disp: got %h want 0000", mon.disp); else n_pass++;
    n_chk++; if (led[7:0] !== 8'h00) $display("FAIL sel_oor_led: got %h want 00", led[7:0]); else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit moved;
    sel = 4'd0;
    pulse(4'b0001, 2);
    tick(2);
    moved = 0;
    for (int i = 0; i < 40 && !moved; i++) begin
      if (mon.an !== 4'b1110) moved = 1;
      else tick();
    end
    n_chk++; if (!moved) $display("FAIL mid_sync: got AN stuck at 1110 for 40 cycles"); else n_pass++;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_chk++; if (mon.an !== 4'b1110) $display("FAIL mid_an: got %b want 1110", mon.an); else n_pass++;
    n_chk++; if (mon.seg !== 7'b1000000) $display("FAIL mid_seg: got %b want 1000000", mon.seg); else n_pass++;
    n_chk++; if (led !== 16'h0001) $display("FAIL mid_led: got %h want 0001", led); else n_pass++;
    n_chk++; if (mon.disp !== 16'h0000) $display("FAIL mid_disp: got %h want 0000", mon.disp); else n_pass++;
    n_chk++; if (dut.cnt[0] !== 16'd0) $display("FAIL mid_cnt: got %0d want 0", dut.cnt[0]); else n_pass++;
    tick(2);
    rst = 1'b0;
    tick(4);
    n_chk++; if (mon.an !== 4'b1110) $display("FAIL resume_d0: got %b want 1110", mon.an); else n_pass++;
    tick();
    n_chk++; if (mon.an !== 4'b1101) $display("FAIL resume_d1: got %b want 1101", mon.an); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_freeze();
    test_overflow();
    test_clr_sel();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_display_bank.md
COUNTER_DISPLAY_BANK -- requirements
Module: counter_display_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of event counters (legal 1..8).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, counter width in bits (legal 4..32, multiple of 4).
REQ-003 SHALL have parameter NUM_DIGITS, default 8, number of seven-segment digits scanned (legal 1..8).
REQ-004 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (legal >= 2).
REQ-005 SHALL have port CLK100MHZ  in  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port inc  in  NUM_CH  per-channel increment pulses, already synchronous to CLK100MHZ.
REQ-008 SHALL have port clr  in  1  synchronous clear of all counters and overflow flags.
REQ-009 SHALL have port sel  in  4  channel select for display.
REQ-010 SHALL have port freeze  in  1  hold current display value when high.
REQ-011 SHALL have port LED  out  16  channel and status indicators.
REQ-012 SHALL have port AN  out  NUM_DIGITS  digit enables, active low, one-hot-zero.
REQ-013 SHALL have port segment  out  7  segments {g,f,e,d,c,b,a}, active low.

Function
REQ-014 Counter i SHALL increment by 1 in the cycle after inc[i] is sampled high; no other input changes it except clr and RESET.
REQ-015 A counter at 2^CNT_WIDTH-1 that is incremented SHALL wrap to 0.
REQ-016 If clr and inc[i] are sampled high together, clr SHALL win; counter reads 0 the next cycle.
REQ-017 Display register SHALL load the selected counter value each cycle freeze is low, one cycle latency from counter to display register.
REQ-018 While freeze is high, display register and latched select SHALL hold; counters keep counting.
REQ-019 If sel >= NUM_CH, display register SHALL load 0 and LED[7:0] SHALL read 0.
REQ-020 LED[7:0] SHALL be one-hot of the latched select, LED[15:8] per REQ-030/031.
REQ-021 Refresh counter SHALL count 0..REFRESH_DIV-1, then wrap to 0; at the wrap cycle the digit index SHALL advance, wrapping from NUM_DIGITS-1 to 0.
REQ-022 AN SHALL drive low only bit [digit index]; segment SHALL show hex nibble [4*idx+3:4*idx] of the display register.
REQ-023 Digits with 4*idx >= CNT_WIDTH SHALL display 0.
REQ-024 Hex encodings SHALL be standard (0 = 1000000, 8 = 0000000, F = 0001110).
REQ-025 AN and segment SHALL be registered and change together in the same cycle.

Reset
REQ-026 RESET high SHALL immediately clear counters, display register, latched select (to 0), refresh counter, digit index and overflow flags.
REQ-027 During reset, outputs SHALL be AN = all ones except bit0 low, segment = 1000000, LED = 16'h0001.
REQ-028 Reset asserted mid-scan or mid-count SHALL abort without glitch beyond the asynchronous clear; scanning resumes at digit 0 after release.
REQ-029 First increment after RESET deassertion SHALL be honoured in the first clock edge with RESET low.

Configuration
REQ-030 With COUNTER_OVERFLOW_EN defined, each channel SHALL have a sticky overflow flag set on wrap (REQ-015), cleared only by clr or RESET; LED[8+i] = flag i, unused bits 0; clr+wrap same cycle clears.
REQ-031 Without COUNTER_OVERFLOW_EN, no flags SHALL exist and LED[15:8] SHALL be 0.

Structure
REQ-032 Package counter_display_pkg SHALL hold the hex-to-segment function, segment constants, and parameter defaults.
REQ-033 Digit scanning (refresh counter, digit index, AN/segment registers) SHALL be sub-module seven_seg_scanner; counters, select and flags stay in the top.

Verification (NUM_CH=4, CNT_WIDTH=16, NUM_DIGITS=4, REFRESH_DIV=4)
REQ-034 RESET pulse -> AN=4'b1110, segment=1000000, LED=16'h0001 during and immediately after reset.
REQ-035 sel=2, 5 pulses on inc[2] -> display register 16'h0005; digit0 segment=0010010, digits1-3 show 0; AN cycles 1110,1101,1011,0111,1110 every 4 clocks.
REQ-036 Counter 1 preloaded via 65535 pulses, one more pulse -> counter 1 = 0, with COUNTER_OVERFLOW_EN LED[9]=1, without LED[15:8]=0.
REQ-037 freeze=1 at count 3, 4 further pulses -> display holds 0003; freeze=0 -> display 0007 one cycle later.
REQ-038 clr and inc[0] same cycle -> counter 0 = 0, overflow flags cleared; sel=5 -> display 0, LED[7:0]=0.
